// File: rtl/qea_host_pkg.sv
// Shared types and constants for the QEA host sequencer: FSM encoding, widths,
// fixed-point one, and the state-RAM row count helper.
package qea_host_pkg;

  localparam int PE_NUM                  = 4;
  localparam int DATA_WIDTH              = 32;
  localparam int STATE_DATA_WIDTH        = 64;
  localparam int STATE_ADDR_WIDTH        = 16;
  localparam int GATE_CONTEXT_DATA_WIDTH = 64;
  localparam int GATE_CONTEXT_ADDR_WIDTH = 16;
  localparam int MAX_QBIT_WIDTH          = 6;
  localparam int NUM_FRAC_BIT            = 30;
  localparam int CNT_WIDTH               = 32;
  localparam int DEF_TIMEOUT_CYCLES      = 1000000;

  localparam logic [DATA_WIDTH-1:0] Q_ONE = DATA_WIDTH'(1) << NUM_FRAC_BIT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_CTX,
    ST_CLR_STATE,
    ST_START,
    ST_RUN,
    ST_DONE
  } qea_state_e;

  // Each state-RAM row holds PE_NUM amplitudes, so q qubits need 2**(q-2) rows,
  // clamped to the addressable range of the state RAM.
  function automatic logic [STATE_ADDR_WIDTH:0] state_rows(input logic [MAX_QBIT_WIDTH-1:0] q);
    logic [STATE_ADDR_WIDTH:0] r;
    if (q < MAX_QBIT_WIDTH'(2))
      r = {{STATE_ADDR_WIDTH{1'b0}}, 1'b1};
    else if (int'(q) >= STATE_ADDR_WIDTH + 2)
      r = {1'b1, {STATE_ADDR_WIDTH{1'b0}}};
    else
      r = {{STATE_ADDR_WIDTH{1'b0}}, 1'b1} << (q - MAX_QBIT_WIDTH'(2));
    return r;
  endfunction

endpackage

// File: rtl/qea_host_sequencer_if.sv
// Bus between the host sequencer, its context stream source and the QEA core.
interface qea_host_sequencer_if;
  import qea_host_pkg::*;

  // Context stream: a beat transfers on a rising edge where s_ctx_valid and
  // s_ctx_ready are both high; the source holds s_ctx_data while valid waits,
  // and s_ctx_ready never depends on s_ctx_valid.
  logic                               s_ctx_valid;
  logic                               s_ctx_ready;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] s_ctx_data;

  logic                               o_ctx_en;
  logic                               o_ctx_wea;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data;
  logic                               o_state_ena;
  logic                               o_state_wea;
  logic [STATE_ADDR_WIDTH-1:0]        o_state_addra;
  logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dina;
  logic [MAX_QBIT_WIDTH-1:0]          o_qbit_num;
  logic                               o_qea_start;
  logic                               i_qea_complete;

  modport master (
    input  s_ctx_valid, s_ctx_data, i_qea_complete,
    output s_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data,
           o_state_ena, o_state_wea, o_state_addra, o_state_dina,
           o_qbit_num, o_qea_start
  );

  modport slave (
    output s_ctx_valid, s_ctx_data, i_qea_complete,
    input  s_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data,
           o_state_ena, o_state_wea, o_state_addra, o_state_dina,
           o_qbit_num, o_qea_start
  );
endinterface

// File: rtl/qea_ctx_writer.sv
// Turns the context stream into registered writes to the QEA context RAM at
// consecutive addresses starting from 0 each time the writer is activated.
module qea_ctx_writer
  import qea_host_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               active,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]   ins_num,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0] s_data,
  output logic                               last_beat,
  output logic                               ctx_en,
  output logic                               ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data
);
  localparam int BW = GATE_CONTEXT_ADDR_WIDTH + 1;

  logic [BW-1:0] beat_q;
  logic          fire;

  assign s_ready   = active;
  assign fire      = s_valid && s_ready;
  assign last_beat = fire && (beat_q == ins_num - BW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q   <= '0;
      ctx_en   <= 1'b0;
      ctx_wea  <= 1'b0;
      ctx_addr <= '0;
      ctx_data <= '0;
    end else begin
      ctx_en  <= fire;
      ctx_wea <= fire;
      if (fire) begin
        ctx_addr <= beat_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
        ctx_data <= s_data;
      end
      // Counter rests at 0 whenever the writer is idle, so every load starts at address 0.
      if (!active)
        beat_q <= '0;
      else if (fire)
        beat_q <= beat_q + BW'(1);
    end
  end
endmodule

// File: rtl/qea_host_sequencer.sv
// Host sequencer for the QEA core: loads context RAM, clears state RAM to |0..0>,
// starts the core and times the run. QEA_TIMEOUT_EN enables a run watchdog.
module qea_host_sequencer
  import qea_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_start,
  input  logic [MAX_QBIT_WIDTH-1:0]        cmd_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0] cmd_ins_num,
  qea_host_sequencer_if.master             bus,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_error,
  output logic [CNT_WIDTH-1:0]             o_cycle_count,
  output qea_state_e                       state_dbg
);
  localparam int SW = PE_NUM * STATE_DATA_WIDTH;

  qea_state_e                       state, next_state;
  logic [GATE_CONTEXT_ADDR_WIDTH:0] ins_q;
  logic [CNT_WIDTH-1:0]             cnt_q;
  logic                             first_q;
  logic                             last_beat, bad_cmd, last_row, complete_ok, timeout_hit;
  logic [STATE_ADDR_WIDTH:0]        rows;
  logic                             state_ena_d, start_d, done_d;
  logic [STATE_ADDR_WIDTH-1:0]      addra_d;
  logic [SW-1:0]                    dina_d;

  assign state_dbg   = state;
  assign o_busy      = (state != ST_IDLE);
  assign bad_cmd     = (state == ST_IDLE) && cmd_start && (cmd_qbit_num < MAX_QBIT_WIDTH'(2));
  assign rows        = state_rows(bus.o_qbit_num);
  assign last_row    = ({1'b0, bus.o_state_addra} == rows - (STATE_ADDR_WIDTH + 1)'(1));
  // The cycle right after the start pulse may still see complete from the previous run.
  assign complete_ok = bus.i_qea_complete && !first_q;

`ifdef QEA_TIMEOUT_EN
  assign timeout_hit = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  qea_ctx_writer u_ctx_writer (
    .clk       (clk),
    .rst       (rst),
    .active    (state == ST_LOAD_CTX),
    .ins_num   (ins_q),
    .s_valid   (bus.s_ctx_valid),
    .s_ready   (bus.s_ctx_ready),
    .s_data    (bus.s_ctx_data),
    .last_beat (last_beat),
    .ctx_en    (bus.o_ctx_en),
    .ctx_wea   (bus.o_ctx_wea),
    .ctx_addr  (bus.o_ctx_addr),
    .ctx_data  (bus.o_ctx_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:      if (cmd_start && !bad_cmd)
                      next_state = (cmd_ins_num == '0) ? ST_CLR_STATE : ST_LOAD_CTX;
      ST_LOAD_CTX:  if (last_beat) next_state = ST_CLR_STATE;
      ST_CLR_STATE: if (last_row) next_state = ST_START;
      ST_START:     next_state = ST_RUN;
      ST_RUN:       if (complete_ok || timeout_hit) next_state = ST_DONE;
      ST_DONE:      next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Registered outputs line up with the state they belong to: state-RAM writes
  // occupy the CLR_STATE cycles and the start pulse occupies the START cycle.
  always_comb begin
    state_ena_d = 1'b0;
    addra_d     = '0;
    dina_d      = '0;
    if (next_state == ST_CLR_STATE) begin
      state_ena_d = 1'b1;
      if (state == ST_CLR_STATE)
        addra_d = bus.o_state_addra + STATE_ADDR_WIDTH'(1);
      else
        dina_d[SW-1 -: STATE_DATA_WIDTH] = {Q_ONE, {DATA_WIDTH{1'b0}}};
    end
    start_d = (next_state == ST_START);
    done_d  = (next_state == ST_DONE) || bad_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_state_ena   <= 1'b0;
      bus.o_state_wea   <= 1'b0;
      bus.o_state_addra <= '0;
      bus.o_state_dina  <= '0;
      bus.o_qea_start   <= 1'b0;
      bus.o_qbit_num    <= '0;
      ins_q             <= '0;
      cnt_q             <= '0;
      first_q           <= 1'b0;
      o_done            <= 1'b0;
      o_error           <= 1'b0;
      o_cycle_count     <= '0;
    end else begin
      bus.o_state_ena   <= state_ena_d;
      bus.o_state_wea   <= state_ena_d;
      bus.o_state_addra <= addra_d;
      bus.o_state_dina  <= dina_d;
      bus.o_qea_start   <= start_d;
      o_done            <= done_d;
      first_q           <= (state == ST_START);
      if (state == ST_IDLE && cmd_start) begin
        bus.o_qbit_num <= cmd_qbit_num;
        ins_q          <= cmd_ins_num;
        o_error        <= bad_cmd;
      end
      if (state == ST_START)
        cnt_q <= CNT_WIDTH'(1);
      else if (state == ST_RUN && !(&cnt_q))
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      if (state == ST_RUN) begin
        if (complete_ok) begin
          o_cycle_count <= cnt_q;
        end else if (timeout_hit) begin
          o_cycle_count <= cnt_q;
          o_error       <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/qea_host_sequencer.md
Name: qea_host_sequencer

Overview:
- Host-side sequencer directly upstream of the QEA core; replaces testbench-driven programming of the core.
- Accepts a valid/ready stream of gate-context words and writes them into QEA's context RAM at consecutive addresses.
- Then initialises QEA state RAM to |0...0>, pulses QEA start, waits for completion and reports the execution cycle count.

Parameters:
- PE_NUM, 4, number of QEA processing elements (state lanes per row)
- DATA_WIDTH, 32, fixed-point component width
- STATE_DATA_WIDTH, 64, one complex amplitude {real, imag}
- STATE_ADDR_WIDTH, 16, QEA state RAM address width
- GATE_CONTEXT_DATA_WIDTH, 64, context word width
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
- MAX_QBIT_WIDTH, 6, qubit-count field width
- NUM_FRAC_BIT, 30, fractional bits; 1.0 = 1<<NUM_FRAC_BIT
- CNT_WIDTH, 32, cycle counter width
- TIMEOUT_CYCLES, 1000000, run watchdog limit (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_start  in  1  run request pulse
- cmd_qbit_num  in  MAX_QBIT_WIDTH  qubits for this run
- cmd_ins_num  in  GATE_CONTEXT_ADDR_WIDTH+1  number of context words
- s_ctx_valid  in  1  context stream valid
- s_ctx_ready  out  1  context stream ready
- s_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context word
- o_ctx_en, o_ctx_wea  out  1 each  to QEA i_ctx_en / i_ctx_wea
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  to QEA i_ctx_addr
- o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  to QEA i_ctx_data
- o_state_ena, o_state_wea  out  1 each  to QEA i_state_ena / i_state_wea
- o_state_addra  out  STATE_ADDR_WIDTH  to QEA i_state_addra
- o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  to QEA i_state_dina
- o_qbit_num  out  MAX_QBIT_WIDTH  to QEA i_qbit_num, latched
- o_qea_start  out  1  to QEA i_start
- i_qea_complete  in  1  from QEA o_complete
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle completion pulse
- o_error  out  1  sticky error flag; cleared by next accepted cmd_start
- o_cycle_count  out  CNT_WIDTH  execution cycles of last run

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: all outputs 0, o_qbit_num 0, FSM IDLE. Reset mid-run aborts immediately; QEA outputs drop to 0 the next edge.
- FSM: IDLE -> LOAD_CTX -> CLR_STATE -> START -> RUN -> DONE -> IDLE.
- Address/data output timing: all QEA-facing outputs are registered.
- IDLE:
  - cmd_start latches qbit_num and ins_num and clears o_error.
  - cmd_qbit_num < 2: set o_error, pulse o_done, remain IDLE.
  - ins_num == 0: skip directly to CLR_STATE.
  - cmd_start in any non-IDLE state is ignored.
- LOAD_CTX:
  - s_ctx_ready = 1.
  - Each valid&ready beat k drives o_ctx_en = o_ctx_wea = 1, o_ctx_addr = k, o_ctx_data = s_ctx_data on the next cycle.
  - Idle cycles drive en/wea 0.
  - After ins_num beats, ready deasserts in the same cycle the last beat is accepted; the FSM goes to CLR_STATE.
- CLR_STATE:
  - Writes R = 2**(qbit_num-2) rows, one per cycle, addresses 0..R-1, ena = wea = 1.
  - Row 0 lane PE_NUM-1 (top 64 bits) = {1<<NUM_FRAC_BIT, 0}; all other lanes and rows are 0.
  - Address counter does not wrap; R is bounded by STATE_ADDR_WIDTH.
- START: o_qea_start = 1 for exactly one cycle; cycle counter reset to 1.
- RUN:
  - Counter increments every cycle.
  - i_qea_complete is ignored in the first cycle after the start pulse to avoid a stale complete.
  - When complete is seen, o_cycle_count = counter and the FSM goes to DONE.
  - Counter saturates at all-ones.
- DONE: o_done = 1 for one cycle, then IDLE.

Optional Feature:
- QEA_TIMEOUT_EN defined: if RUN lasts TIMEOUT_CYCLES without complete, set o_error, o_cycle_count = TIMEOUT_CYCLES, go to DONE.
- QEA_TIMEOUT_EN undefined: RUN waits indefinitely and o_error is raised only by a bad qbit_num.

Decomposition:
- Package qea_host_pkg: FSM state enum; constant Q_ONE = 1<<NUM_FRAC_BIT; helper function for rows = 2**(q-2).
- Sub-module qea_ctx_writer: stream-to-RAM-port writer (ready, address counter, registered en/wea/addr/data) used by LOAD_CTX.

Test Plan:
- Reset then cmd_start with qbit 3, ins 87, 87-word stream -> ctx addrs 0..86 with matching data, 87 write cycles, s_ctx_ready low afterwards.
- Same run, CLR_STATE -> rows 0 and 1 written; row0 = {64'h40000000_00000000, 0, 0, 0}, row1 = all 0; start pulse width 1 cycle.
- Model complete 50 cycles after start -> o_cycle_count = 50, o_done pulse 1 cycle, o_busy low after.
- Stream stalls: valid toggles every other cycle -> addrs stay contiguous, no write issued on idle cycles.
- cmd_qbit_num = 1 -> o_error = 1, o_done pulse, no QEA writes; cmd_start during RUN -> ignored.
- rst during LOAD_CTX at beat 10 -> all outputs 0 next cycle; new run restarts at addr 0. With QEA_TIMEOUT_EN and TIMEOUT_CYCLES = 100, no complete -> o_error = 1, count = 100.
